// File: rtl/id_ex_stage_r0_pkg.sv
// rtl/id_ex_stage_r0_pkg.sv - shared ALU opcodes and control bundle for the pipeline stages
package id_ex_stage_r0_pkg;

   localparam int ALU_OP_WIDTH = 4;

   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 4'd0;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 4'd1;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_AND = 4'd2;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OR  = 4'd3;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR = 4'd4;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT = 4'd5;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL = 4'd6;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL = 4'd7;

   // Control bits carried from ID into EX, in the field order every stage uses.
   typedef struct packed {
      logic alu_src;
      logic mem_read;
      logic mem_write;
      logic write_reg;
      logic mem_to_reg;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   // An empty slot must never carry live control bits.
   function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic valid);
      return valid ? c : CTRL_NOP;
   endfunction

endpackage

// File: rtl/load_use_detect_r0.sv
// rtl/load_use_detect_r0.sv - combinational load-use hazard detect between EX and ID
module load_use_detect_r0 #(
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      ex_valid,
   input  logic                      ex_mem_read,
   input  logic [REG_ADDR_WIDTH-1:0] ex_reg_to_write,
   input  logic                      id_valid,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs,
   input  logic [REG_ADDR_WIDTH-1:0] id_rt,
   input  logic                      id_uses_rt,
   output logic                      hz
);

   logic ex_is_load;
   logic rs_match;
   logic rt_match;

   // A load into r0 produces nothing to forward, so it can never be a hazard source.
   always_comb begin
      ex_is_load = ex_valid & ex_mem_read & (ex_reg_to_write != '0);
      rs_match   = (ex_reg_to_write == id_rs);
      rt_match   = id_uses_rt & (ex_reg_to_write == id_rt);
      hz         = ex_is_load & id_valid & (rs_match | rt_match);
   end

endmodule

// File: rtl/id_ex_stage_r0.sv
// rtl/id_ex_stage_r0.sv - ID/EX pipeline register with load-use stall and bubble insertion
module id_ex_stage_r0 #(
   parameter int BIT_WIDTH      = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int ALU_OP_WIDTH   = id_ex_stage_r0_pkg::ALU_OP_WIDTH,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      id_valid,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs,
   input  logic [REG_ADDR_WIDTH-1:0] id_rt,
   input  logic [REG_ADDR_WIDTH-1:0] id_rd,
   input  logic                      id_usesRt,
   input  logic [BIT_WIDTH-1:0]      id_rsData,
   input  logic [BIT_WIDTH-1:0]      id_rtData,
   input  logic [BIT_WIDTH-1:0]      id_imm,
   input  logic [ALU_OP_WIDTH-1:0]   id_aluOp,
   input  logic                      id_aluSrc,
   input  logic                      id_regDst,
   input  logic                      id_memRead,
   input  logic                      id_memWrite,
   input  logic                      id_writeReg,
   input  logic                      id_memToReg,
   input  logic                      flush,
   output logic                      stall,
   output logic                      ex_valid,
   output logic [REG_ADDR_WIDTH-1:0] ex_rs,
   output logic [REG_ADDR_WIDTH-1:0] ex_rt,
   output logic [REG_ADDR_WIDTH-1:0] ex_regToWrite,
   output logic [BIT_WIDTH-1:0]      ex_rsData,
   output logic [BIT_WIDTH-1:0]      ex_rtData,
   output logic [BIT_WIDTH-1:0]      ex_imm,
   output logic [ALU_OP_WIDTH-1:0]   ex_aluOp,
   output logic                      ex_aluSrc,
   output logic                      ex_memRead,
   output logic                      ex_memWrite,
   output logic                      ex_writeReg,
   output logic                      ex_memToReg,
   output logic [CNT_WIDTH-1:0]      stall_count
);

   import id_ex_stage_r0_pkg::*;

   logic  hz;
   logic  bubble;
   ctrl_t id_ctrl;
   ctrl_t ex_ctrl;

   load_use_detect_r0 #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_detect (
      .ex_valid        (ex_valid),
      .ex_mem_read     (ex_ctrl.mem_read),
      .ex_reg_to_write (ex_regToWrite),
      .id_valid        (id_valid),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rt      (id_usesRt),
      .hz              (hz)
   );

   // A flush kills the ID instruction outright, so it also suppresses the stall.
   always_comb begin
      stall             = hz & ~flush;
      bubble            = hz | flush;
      id_ctrl.alu_src    = id_aluSrc;
      id_ctrl.mem_read   = id_memRead;
      id_ctrl.mem_write  = id_memWrite;
      id_ctrl.write_reg  = id_writeReg;
      id_ctrl.mem_to_reg = id_memToReg;
   end

   // Pipeline register: bubble on flush/hazard, otherwise capture ID with control gated by id_valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid      <= 1'b0;
         ex_rs         <= '0;
         ex_rt         <= '0;
         ex_regToWrite <= '0;
         ex_rsData     <= '0;
         ex_rtData     <= '0;
         ex_imm        <= '0;
         ex_aluOp      <= '0;
         ex_ctrl       <= CTRL_NOP;
      end else if (bubble) begin
         ex_valid      <= 1'b0;
         ex_rs         <= '0;
         ex_rt         <= '0;
         ex_regToWrite <= '0;
         ex_rsData     <= '0;
         ex_rtData     <= '0;
         ex_imm        <= '0;
         ex_aluOp      <= '0;
         ex_ctrl       <= CTRL_NOP;
      end else begin
         ex_valid      <= id_valid;
         ex_rs         <= id_rs;
         ex_rt         <= id_rt;
         ex_regToWrite <= id_regDst ? id_rd : id_rt;
         ex_rsData     <= id_rsData;
         ex_rtData     <= id_rtData;
         ex_imm        <= id_imm;
         ex_aluOp      <= id_valid ? id_aluOp : '0;
         ex_ctrl       <= ctrl_gate(id_ctrl, id_valid);
      end
   end

   // Count inserted load-use bubbles, holding at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + 1'b1;
      end
   end

   // Unpack the registered control bundle onto the EX-facing ports.
   always_comb begin
      ex_aluSrc   = ex_ctrl.alu_src;
      ex_memRead  = ex_ctrl.mem_read;
      ex_memWrite = ex_ctrl.mem_write;
      ex_writeReg = ex_ctrl.write_reg;
      ex_memToReg = ex_ctrl.mem_to_reg;
   end

endmodule
